// File: rtl/uart_led_ctrl.sv
// Multi-channel LED controller fed by decoded UART packets: OFF/ON/BLINK/PWM per channel,
// millisecond tick prescaler, ack/err pulses. Define UART_LED_PWM_EN to build PWM mode (cmd 0x03).
module uart_led_ctrl #(
  parameter int CH_NUM   = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pkt_valid,
  input  logic [7:0]        pkt_cmd,
  input  logic [7:0]        pkt_chan,
  input  logic [15:0]       pkt_arg0,
  input  logic [15:0]       pkt_arg1,
  output logic [CH_NUM-1:0] led,
  output logic              cmd_ack,
  output logic              cmd_err
);

  localparam int            DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [7:0]    CH_LIM   = 8'(CH_NUM);
  localparam logic [7:0]    C_OFF     = 8'h00;
  localparam logic [7:0]    C_ON      = 8'h01;
  localparam logic [7:0]    C_BLINK   = 8'h02;
  localparam logic [7:0]    C_PWM     = 8'h03;
  localparam logic [7:0]    C_ALL_OFF = 8'h04;
  localparam logic [7:0]    C_ALL_ON  = 8'h08;

  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_BLK_ON,
    S_BLK_OFF,
    S_PWM
  } ch_state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;

  ch_state_t   st      [CH_NUM];
  ch_state_t   st_nx   [CH_NUM];
  logic [15:0] on_len  [CH_NUM];
  logic [15:0] on_nx   [CH_NUM];
  logic [15:0] off_len [CH_NUM];
  logic [15:0] off_nx  [CH_NUM];
  logic [15:0] ph_cnt  [CH_NUM];
  logic [15:0] ph_nx   [CH_NUM];
  logic [CH_NUM-1:0] led_nx;
`ifdef UART_LED_PWM_EN
  logic [7:0] pwm_cnt;
  logic [7:0] duty    [CH_NUM];
  logic [7:0] duty_nx [CH_NUM];
`endif

  logic chan_cmd, glob_cmd, chan_ok, args_ok, accept, reject, hit;

  assign tick = (div_cnt == DIV_LAST);

  always_comb begin
    chan_cmd = (pkt_cmd == C_OFF) || (pkt_cmd == C_ON) || (pkt_cmd == C_BLINK);
`ifdef UART_LED_PWM_EN
    chan_cmd = chan_cmd || (pkt_cmd == C_PWM);
`endif
    glob_cmd = (pkt_cmd == C_ALL_ON) || (pkt_cmd == C_ALL_OFF);
    chan_ok  = (pkt_chan == 8'hFF) || (pkt_chan < CH_LIM);
    args_ok  = !((pkt_cmd == C_BLINK) && ((pkt_arg0 == '0) || (pkt_arg1 == '0)));
    accept   = pkt_valid && (glob_cmd || (chan_cmd && chan_ok && args_ok));
    reject   = pkt_valid && !accept;
  end

  always_comb begin
    hit    = 1'b0;
    led_nx = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      st_nx[i]  = st[i];
      on_nx[i]  = on_len[i];
      off_nx[i] = off_len[i];
      ph_nx[i]  = ph_cnt[i];
`ifdef UART_LED_PWM_EN
      duty_nx[i] = duty[i];
`endif
      if (tick) begin
        if (st[i] == S_BLK_ON) begin
          if (ph_cnt[i] + 16'd1 == on_len[i]) begin
            st_nx[i] = S_BLK_OFF;
            ph_nx[i] = '0;
          end else begin
            ph_nx[i] = ph_cnt[i] + 16'd1;
          end
        end else if (st[i] == S_BLK_OFF) begin
          if (ph_cnt[i] + 16'd1 == off_len[i]) begin
            st_nx[i] = S_BLK_ON;
            ph_nx[i] = '0;
          end else begin
            ph_nx[i] = ph_cnt[i] + 16'd1;
          end
        end
      end
      // A command overrides any phase step computed above for the same cycle
      hit = accept && (glob_cmd || (pkt_chan == 8'hFF) || (pkt_chan == 8'(i)));
      if (hit) begin
        ph_nx[i] = '0;
        case (pkt_cmd)
          C_ON, C_ALL_ON: st_nx[i] = S_ON;
          C_BLINK: begin
            st_nx[i]  = S_BLK_ON;
            on_nx[i]  = pkt_arg0;
            off_nx[i] = pkt_arg1;
          end
`ifdef UART_LED_PWM_EN
          C_PWM: begin
            st_nx[i]   = S_PWM;
            duty_nx[i] = pkt_arg0[7:0];
          end
`endif
          default: st_nx[i] = S_OFF;
        endcase
      end
      case (st_nx[i])
        S_ON, S_BLK_ON: led_nx[i] = 1'b1;
`ifdef UART_LED_PWM_EN
        S_PWM:          led_nx[i] = (pwm_cnt < duty_nx[i]);
`endif
        default:        led_nx[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt <= '0;
      led     <= '0;
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
`ifdef UART_LED_PWM_EN
      pwm_cnt <= '0;
`endif
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        st[i]      <= S_OFF;
        on_len[i]  <= '0;
        off_len[i] <= '0;
        ph_cnt[i]  <= '0;
`ifdef UART_LED_PWM_EN
        duty[i]    <= '0;
`endif
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      led     <= led_nx;
      cmd_ack <= accept;
      cmd_err <= reject;
`ifdef UART_LED_PWM_EN
      pwm_cnt <= pwm_cnt + 8'd1;
`endif
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        st[i]      <= st_nx[i];
        on_len[i]  <= on_nx[i];
        off_len[i] <= off_nx[i];
        ph_cnt[i]  <= ph_nx[i];
`ifdef UART_LED_PWM_EN
        duty[i]    <= duty_nx[i];
`endif
      end
    end
  end

endmodule
